adc_spi_capture: RTL and testbench
==================================

Name: adc_spi_capture

Overview:
- Upstream stage of the ADC-to-BCD/UART/display path.
- Drives a 12-bit MCP3202-style SPI ADC: generates sclk, cs_n and d_in, and shifts in d_out.
- Presents each completed conversion as a held 12-bit word with a one-cycle valid strobe.
- Replaces free-running sclk-domain capture with a single-clock, frame-locked sequencer.

Parameters:
- CLK_DIV, 12, clk cycles per sclk half-period; minimum 2 (12 at 50 MHz gives about 2.08 MHz sclk).
- GAP_CYCLES, 32, clk cycles cs_n is held high between frames; minimum 25 (tCSH).
- SGL_DIFF, 1, config bit 2: 1 = single-ended, 0 = differential.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-frame request; sampled only in IDLE.
- cont  in  1  free-run: re-trigger automatically after GAP.
- ch_sel  in  1  channel (ODD/SIGN bit); latched at frame start.
- sclk  out  1  SPI clock, registered, idles low.
- cs_n  out  1  chip select, registered, idles high.
- d_in  out  1  config bits to the ADC, registered.
- d_out  in  1  serial data from the ADC.
- sample  out  12  last completed conversion, MSB-first assembled.
- sample_valid  out  1  one-cycle pulse when sample updates.
- busy  out  1  high from cs_n low through the end of GAP.

Behaviour:
- Reset (reset=0 at a clk edge): sclk=0, cs_n=1, d_in=0, sample=0, sample_valid=0, busy=0, state=IDLE, divider=0. Reset mid-frame aborts on that edge; no partial sample is output.
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE:
  - Exit when start=1 or cont=1. On that edge: latch ch_sel, cs_n<=0, busy<=1, d_in<=1 (start bit), state<=SETUP.
  - start while busy=1 is ignored (no queueing).
- SETUP: wait CLK_DIV cycles, then sclk<=1 (rise #1), state<=SHIFT.
- SHIFT:
  - sclk toggles every CLK_DIV cycles. Rise k occurs CLK_DIV*(2k-1) cycles after cs_n falls.
  - d_in changes only on sclk falls. Sequence per rise #1..#4: 1, SGL_DIFF, ch_sel latched, 1 (MSBF). d_in=0 after fall #4.
  - Rise #5 is the null bit; d_out is ignored.
  - On the clk edge producing rises #6..#17, shift d_out into the shift register (first bit = sample[11]).
  - On the edge producing fall #17: sclk<=0, cs_n<=1, sample<=shift register, sample_valid<=1 (one cycle), state<=GAP.
- GAP: cs_n high for GAP_CYCLES cycles, then busy<=0 and state<=IDLE. If cont=1 at that point, IDLE immediately re-starts on the next edge.
- Latency, default parameters: start at cycle 0 → cs_n low at cycle 1 → sample_valid at cycle 409 → busy low at cycle 441.
- Divider counter wraps 0..CLK_DIV-1. It is cleared on entry to SETUP so frame phase is deterministic.
- cont deasserted mid-frame: the current frame completes normally, then the block idles.
- ch_sel changes mid-frame have no effect on the current frame.

Optional Feature:
- Macro: ADC_CAPTURE_AVG4_EN.
- Defined:
  - Each completed frame adds to a 14-bit accumulator with a 2-bit frame count.
  - On every 4th frame: sample<=sum[13:2], sample_valid pulses, accumulator clears.
  - A change of latched ch_sel versus the previous frame clears the accumulator and count.
  - Reset clears both.
- Undefined: every frame produces sample_valid, as above; no accumulator logic is present.

Decomposition:
- Package adc_capture_pkg:
  - state enum {IDLE, SETUP, SHIFT, GAP}.
  - FRAME_CLKS=17, CFG_BITS=4, NULL_BIT_IDX=5, DATA_BITS=12.
  - MSBF_BIT=1, START_BIT=1.
- Sub-module adc_sclk_gen: divider, sclk register, and one-cycle rise_evt/fall_evt strobes. Enabled and cleared by the sequencer.

Test Plan:
- Single conversion: reset, then start pulse with ch_sel=0, ADC model returning 12'hA5C → sample=12'hA5C, sample_valid exactly 1 cycle at cycle 409, 17 sclk rises, d_in = 1,1,0,1 on rises 1-4.
- Channel 1 with SGL_DIFF=0: start with ch_sel=1 → d_in = 1,0,1,1; model 12'h001 → sample=12'h001.
- Continuous: cont=1, model returns 12'hFFF, 12'h000, 12'h800 → three valid pulses 440+ cycles apart, cs_n high ≥ GAP_CYCLES between frames, samples in order.
- Busy start ignored: second start pulse at cycle 100 → exactly one frame, one sample_valid.
- Reset mid-frame: reset=0 at cycle 200 → next edge cs_n=1, sclk=0, busy=0, sample unchanged (0), no valid pulse; then a new start produces a correct frame.
- ADC_CAPTURE_AVG4_EN: cont=1, samples 100, 200, 300, 404 → single valid pulse after the 4th frame with sample=251; a ch_sel toggle after frame 2 restarts the count.

Source files
------------

// File: rtl/adc_capture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_capture_pkg: shared types and frame constants for ADC capture. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int   FRAME_CLKS   = 17;
  localparam int   CFG_BITS     = 4;
  localparam int   NULL_BIT_IDX = 5;
  localparam int   DATA_BITS    = 12;
  localparam logic MSBF_BIT     = 1'b1;
  localparam logic START_BIT    = 1'b1;

  // Config bit the ADC samples on sclk rise number rise_idx (1-based).
  function automatic logic cfg_bit(input logic [4:0] rise_idx,
                                   input logic       sgl_diff,
                                   input logic       odd_sign);
    logic b;
    b = 1'b0;
    case (rise_idx)
      5'd1:    b = START_BIT;
      5'd2:    b = sgl_diff;
      5'd3:    b = odd_sign;
      5'd4:    b = MSBF_BIT;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_spi_capture_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_spi_capture_if: SPI pins between the capture block and the ADC. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface adc_spi_capture_if;
  logic sclk;
  logic cs_n;
  logic d_in;
  logic d_out;

  modport master (output sclk, output cs_n, output d_in, input d_out);
  modport slave  (input sclk, input cs_n, input d_in, output d_out);
endinterface
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_sclk_gen: sclk divider with strobes marking the edge that      |
// | produces each sclk rise/fall. Rev 1.0                              |
// +--------------------------------------------------------------------+
module adc_sclk_gen #(
  parameter int CLK_DIV = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise_evt,
  output logic fall_evt
);
  localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             tick;

  assign tick     = en && (div == DIV_LAST);
  assign rise_evt = tick && !sclk;
  assign fall_evt = tick && sclk;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) sclk <= ~sclk;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_spi_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_spi_capture: frame-locked MCP3202-style SPI ADC sequencer.     |
// | Optional 4-frame averaging: ADC_CAPTURE_AVG4_EN. Rev 1.0           |
// +--------------------------------------------------------------------+
module adc_spi_capture
  import adc_capture_pkg::*;
#(
  parameter int CLK_DIV    = 12,
  parameter int GAP_CYCLES = 32,
  parameter bit SGL_DIFF   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cont,
  input  logic                 ch_sel,
  adc_spi_capture_if.master    spi,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy
);
  localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [4:0]       LAST_RISE = 5'(FRAME_CLKS);
  localparam logic [4:0]       NULL_RISE = 5'(NULL_BIT_IDX);
  localparam logic [4:0]       CFG_RISE  = 5'(CFG_BITS);

  state_t               state, state_nxt;
  logic                 ch_lat, ch_nxt;
  logic                 cs_n_q, cs_n_nxt;
  logic                 d_in_q, d_in_nxt;
  logic [4:0]           rise_cnt, rise_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [DATA_BITS-1:0] sample_nxt;
  logic                 valid_nxt, busy_nxt, frame_done;
  logic [GAP_W-1:0]     gap_cnt, gap_nxt;
  logic                 gen_en, sclk_q, rise_evt, fall_evt;

`ifdef ADC_CAPTURE_AVG4_EN
  localparam int        ACC_W = DATA_BITS + 2;
  logic [ACC_W-1:0]     acc, acc_nxt, avg_sum;
  logic [1:0]           fcnt, cnt_nxt, base_cnt;
  logic                 last_ch, last_ch_nxt;
`endif

  assign gen_en    = (state == SETUP) || (state == SHIFT);
  assign spi.sclk  = sclk_q;
  assign spi.cs_n  = cs_n_q;
  assign spi.d_in  = d_in_q;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (gen_en),
    .clr      (!gen_en),
    .sclk     (sclk_q),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ch_lat       <= 1'b0;
      cs_n_q       <= 1'b1;
      d_in_q       <= 1'b0;
      rise_cnt     <= '0;
      shift_reg    <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      gap_cnt      <= '0;
`ifdef ADC_CAPTURE_AVG4_EN
      acc          <= '0;
      fcnt         <= '0;
      last_ch      <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      ch_lat       <= ch_nxt;
      cs_n_q       <= cs_n_nxt;
      d_in_q       <= d_in_nxt;
      rise_cnt     <= rise_nxt;
      shift_reg    <= shift_nxt;
      sample       <= sample_nxt;
      sample_valid <= valid_nxt;
      busy         <= busy_nxt;
      gap_cnt      <= gap_nxt;
`ifdef ADC_CAPTURE_AVG4_EN
      acc          <= acc_nxt;
      fcnt         <= cnt_nxt;
      last_ch      <= last_ch_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch_lat;
    cs_n_nxt   = cs_n_q;
    d_in_nxt   = d_in_q;
    rise_nxt   = rise_cnt;
    shift_nxt  = shift_reg;
    sample_nxt = sample;
    valid_nxt  = 1'b0;
    busy_nxt   = busy;
    gap_nxt    = gap_cnt;
    frame_done = 1'b0;

    case (state)
      IDLE: begin
        if (start || cont) begin
          ch_nxt    = ch_sel;
          cs_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          d_in_nxt  = START_BIT;
          rise_nxt  = '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (rise_evt) begin
          rise_nxt  = rise_cnt + 5'd1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // rise_cnt holds the number of rises already issued.
        if (rise_evt) begin
          rise_nxt = rise_cnt + 5'd1;
          if (rise_cnt >= NULL_RISE) shift_nxt = {shift_reg[DATA_BITS-2:0], spi.d_out};
        end else if (fall_evt) begin
          if (rise_cnt == LAST_RISE) begin
            cs_n_nxt   = 1'b1;
            gap_nxt    = '0;
            state_nxt  = GAP;
            frame_done = 1'b1;
          end else if (rise_cnt <= CFG_RISE) begin
            d_in_nxt = cfg_bit(rise_cnt + 5'd1, SGL_DIFF, ch_lat);
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef ADC_CAPTURE_AVG4_EN
    acc_nxt     = acc;
    cnt_nxt     = fcnt;
    last_ch_nxt = last_ch;
    avg_sum     = '0;
    base_cnt    = '0;
    if (frame_done) begin
      // A channel switch discards the partial average of the old channel.
      base_cnt    = (ch_lat == last_ch) ? fcnt : 2'd0;
      avg_sum     = ((ch_lat == last_ch) ? acc : '0) + ACC_W'(shift_reg);
      last_ch_nxt = ch_lat;
      if (base_cnt == 2'd3) begin
        sample_nxt = avg_sum[ACC_W-1:2];
        valid_nxt  = 1'b1;
        acc_nxt    = '0;
        cnt_nxt    = '0;
      end else begin
        acc_nxt = avg_sum;
        cnt_nxt = base_cnt + 2'd1;
      end
    end
`else
    if (frame_done) begin
      sample_nxt = shift_reg;
      valid_nxt  = 1'b1;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_adc_spi_capture: directed bench with an MCP3202-style ADC model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_adc_spi_capture;

  logic        clk, reset, start, start_b, cont, ch_sel, use_b;
  logic        adc_dout;
  logic [11:0] sample_a, sample_b;
  logic        valid_a, valid_b, busy_a, busy_b;

  int          n_checks = 0;
  int          n_fail   = 0;

  // ADC model state
  logic [11:0] words [0:15];
  logic        ch_tab [0:15];
  logic [11:0] cur_word;
  int          frame_idx = 0;
  int          falls = 0;
  int          rises = 0;
  logic [3:0]  din_bits = 4'b0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;

  // results of run_cont
  int          res_cyc  [0:15];
  logic [11:0] res_samp [0:15];
  int          res_n, res_gap, res_frames;

  adc_spi_capture_if ifa ();
  adc_spi_capture_if ifb ();

  assign ifa.d_out = adc_dout;
  assign ifb.d_out = adc_dout;

  adc_spi_capture dut_a (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .ch_sel(ch_sel),
    .spi(ifa), .sample(sample_a), .sample_valid(valid_a), .busy(busy_a)
  );

  adc_spi_capture #(.CLK_DIV(2), .GAP_CYCLES(25), .SGL_DIFF(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cont(1'b0), .ch_sel(ch_sel),
    .spi(ifb), .sample(sample_b), .sample_valid(valid_b), .busy(busy_b)
  );

  wire        s_sclk   = use_b ? ifb.sclk : ifa.sclk;
  wire        s_cs_n   = use_b ? ifb.cs_n : ifa.cs_n;
  wire        s_din    = use_b ? ifb.d_in : ifa.d_in;
  wire        s_valid  = use_b ? valid_b  : valid_a;
  wire        s_busy   = use_b ? busy_b   : busy_a;
  wire [11:0] s_sample = use_b ? sample_b : sample_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC: drives d_out on sclk falls, samples d_in on sclk rises.
  always @(s_cs_n, s_sclk) begin
    if (s_cs_n === 1'b0 && cs_prev === 1'b1) begin
      cur_word  = words[frame_idx % 16];
      frame_idx = frame_idx + 1;
      falls     = 0;
      rises     = 0;
      din_bits  = 4'b0;
      adc_dout  = 1'b0;
    end else if (s_cs_n === 1'b0 && s_sclk === 1'b1 && sclk_prev === 1'b0) begin
      rises = rises + 1;
      if (rises <= 4) din_bits = {din_bits[2:0], s_din};
    end else if (s_cs_n === 1'b0 && s_sclk === 1'b0 && sclk_prev === 1'b1) begin
      falls = falls + 1;
      if (falls >= 5 && falls <= 16) adc_dout = cur_word[16 - falls];
      else                           adc_dout = 1'b0;
    end
    cs_prev   = s_cs_n;
    sclk_prev = s_sclk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input bit b, input logic ch, input logic [11:0] word,
                           input int exp_v, input int exp_b, input logic [3:0] exp_din);
    int n, vcnt, vcyc, bcyc, f0;
    logic [11:0] vs;
    use_b = b;
    f0 = frame_idx;
    words[f0 % 16] = word;
    ch_sel = ch;
    @(negedge clk);
    if (b) start_b = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_b = 1'b0; n = 1;
    check_eq("cs_n_low_cycle1", s_cs_n, 0);
    check_eq("busy_high_cycle1", s_busy, 1);
    vcnt = 0; vcyc = -1; bcyc = -1; vs = '0;
    while (n < 2000 && bcyc < 0) begin
      @(negedge clk);
      n++;
      if (s_valid) begin vcnt++; vcyc = n; vs = s_sample; end
      if (!s_busy) bcyc = n;
    end
    check_eq("valid_pulse_cycles", vcnt, 1);
    check_eq("valid_cycle", vcyc, exp_v);
    check_eq("sample", vs, word);
    check_eq("busy_low_cycle", bcyc, exp_b);
    check_eq("sclk_rises", rises, 17);
    check_eq("d_in_cfg_bits", din_bits, exp_din);
    check_eq("frames_started", frame_idx - f0, 1);
  endtask

  task automatic run_cont(input int nfr);
    int n, f0;
    use_b = 1'b0;
    f0 = frame_idx;
    res_n = 0; res_gap = 0;
    @(negedge clk);
    ch_sel = ch_tab[0];
    cont = 1'b1;
    n = 0;
    while (n < 441 * nfr + 100) begin
      @(negedge clk);
      n++;
      if (frame_idx - f0 >= nfr) cont = 1'b0;
      else                       ch_sel = ch_tab[(frame_idx - f0) % 16];
      if (s_valid) begin
        if (res_n < 16) begin res_cyc[res_n] = n; res_samp[res_n] = s_sample; end
        res_n++;
      end
      if (res_n == 1 && s_cs_n) res_gap++;
    end
    cont = 1'b0;
    res_frames = frame_idx - f0;
  endtask

  initial begin
    int n, vcnt;
    reset = 1'b0; start = 1'b0; start_b = 1'b0; cont = 1'b0; ch_sel = 1'b0; use_b = 1'b0;
    for (int i = 0; i < 16; i++) begin words[i] = '0; ch_tab[i] = 1'b0; end
    repeat (3) @(negedge clk);
    check_eq("rst_cs_n", ifa.cs_n, 1);
    check_eq("rst_sclk", ifa.sclk, 0);
    check_eq("rst_d_in", ifa.d_in, 0);
    check_eq("rst_sample", sample_a, 0);
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_b_cs_n", ifb.cs_n, 1);
    reset = 1'b1;
    @(negedge clk);

`ifdef ADC_CAPTURE_AVG4_EN
    words[0] = 12'd100; words[1] = 12'd200; words[2] = 12'd300; words[3] = 12'd404;
    words[4] = 12'd10;  words[5] = 12'd20;  words[6] = 12'd40;  words[7] = 12'd80;
    words[8] = 12'd120; words[9] = 12'd160;
    for (int i = 6; i < 10; i++) ch_tab[i] = 1'b1;
    run_cont(10);
    check_eq("avg_valid_count", res_n, 2);
    check_eq("avg_first_sample", res_samp[0], 12'd251);
    check_eq("avg_first_cycle", res_cyc[0], 1732);
    check_eq("avg_after_ch_switch", res_samp[1], 12'd100);
    check_eq("avg_second_cycle", res_cyc[1], 4378);
    check_eq("avg_frames", res_frames, 10);
    check_eq("avg_busy_end", busy_a, 0);
`else
    // single conversion, channel 0, single-ended
    run_frame(1'b0, 1'b0, 12'hA5C, 409, 441, 4'b1101);
    // channel 1, differential, minimum divider/gap
    run_frame(1'b1, 1'b1, 12'h001, 69, 94, 4'b1011);

    // start while busy is ignored
    use_b = 1'b0;
    words[frame_idx % 16] = 12'h3C3;
    begin
      int f0;
      f0 = frame_idx;
      ch_sel = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; n = 1; vcnt = 0;
      while (n < 500) begin
        @(negedge clk);
        n++;
        start = (n == 100);
        if (valid_a) vcnt++;
      end
      check_eq("busy_start_valids", vcnt, 1);
      check_eq("busy_start_frames", frame_idx - f0, 1);
      check_eq("busy_start_sample", sample_a, 12'h3C3);
    end

    // reset mid-frame
    words[frame_idx % 16] = 12'h777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1; vcnt = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (valid_a) vcnt++;
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_cs_n", ifa.cs_n, 1);
    check_eq("abort_sclk", ifa.sclk, 0);
    check_eq("abort_busy", busy_a, 0);
    check_eq("abort_sample", sample_a, 0);
    check_eq("abort_valid", valid_a + vcnt, 0);
    reset = 1'b1;
    @(negedge clk);
    run_frame(1'b0, 1'b0, 12'h5A5, 409, 441, 4'b1101);

    // continuous conversions
    words[frame_idx % 16]       = 12'hFFF;
    words[(frame_idx + 1) % 16] = 12'h000;
    words[(frame_idx + 2) % 16] = 12'h800;
    run_cont(3);
    check_eq("cont_valid_count", res_n, 3);
    check_eq("cont_sample0", res_samp[0], 12'hFFF);
    check_eq("cont_sample1", res_samp[1], 12'h000);
    check_eq("cont_sample2", res_samp[2], 12'h800);
    check_eq("cont_cycle0", res_cyc[0], 409);
    check_eq("cont_cycle1", res_cyc[1], 850);
    check_eq("cont_cycle2", res_cyc[2], 1291);
    check_eq("cont_cs_n_high_cycles", res_gap, 33);
    check_eq("cont_frames", res_frames, 3);
    check_eq("cont_busy_end", busy_a, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
